// File: rtl/seg7_serial_driver.sv
// Serialises a 64-bit active-low 7-segment pattern MSB-first into daisy-chained shift registers, then latches.
// Optional blink masking at snapshot time is compiled in when SEG7_BLINK_EN is defined.
module seg7_serial_driver #(
   parameter int unsigned DIV          = 2,
   parameter int unsigned REFRESH      = 100000,
   parameter int unsigned BLINK_PERIOD = 25000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] pattern,
   input  logic        start,
   input  logic [7:0]  blink_mask,
   output logic        busy,
   output logic        done,
   output logic        seg_clk,
   output logic        seg_dout,
   output logic        seg_clrn,
   output logic        seg_en
);

   localparam int unsigned DW = $clog2(DIV + 1);
   localparam int unsigned RW = (REFRESH == 0) ? 1 : $clog2(REFRESH + 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [RW-1:0] REF_LAST = (REFRESH == 0) ? '0 : RW'(REFRESH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t        state_q, state_d;
   logic [62:0]   shreg_q, shreg_d;
   logic [5:0]    bit_q, bit_d;
   logic [DW-1:0] div_q, div_d;
   logic [RW-1:0] ref_q, ref_d;
   logic          busy_d, done_d, seg_clk_d, seg_dout_d, seg_en_d;
   logic [63:0]   snap;
   logic          refresh_hit;

`ifdef SEG7_BLINK_EN
   localparam int unsigned BW = (BLINK_PERIOD <= 1) ? 1 : $clog2(BLINK_PERIOD);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIOD - 1);

   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   // Free-running blink phase generator
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   // Blanked digits load as all-segments-off (active-low, so 8'hFF)
   always_comb begin
      snap = pattern;
      for (int i = 0; i < 8; i++) begin
         if (blink_phase && blink_mask[i]) snap[i*8 +: 8] = 8'hFF;
      end
   end
`else
   logic unused_blink;
   assign unused_blink = ^{blink_mask, 32'(BLINK_PERIOD)};
   assign snap         = pattern;
`endif

   assign refresh_hit = (REFRESH != 0) && (ref_q == REF_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bit_q    <= '0;
         div_q    <= '0;
         ref_q    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         seg_clk  <= 1'b0;
         seg_dout <= 1'b0;
         seg_clrn <= 1'b0;
         seg_en   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         ref_q    <= ref_d;
         busy     <= busy_d;
         done     <= done_d;
         seg_clk  <= seg_clk_d;
         seg_dout <= seg_dout_d;
         seg_clrn <= 1'b1;
         seg_en   <= seg_en_d;
      end
   end

   // shreg holds the bits still to be sent; the bit on the wire lives in seg_dout
   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_d      = bit_q;
      div_d      = div_q;
      ref_d      = ref_q;
      busy_d     = busy;
      done_d     = 1'b0;
      seg_clk_d  = seg_clk;
      seg_dout_d = seg_dout;
      seg_en_d   = seg_en;
      case (state_q)
         IDLE: begin
            if (start || refresh_hit) begin
               state_d    = SHIFT;
               shreg_d    = snap[62:0];
               seg_dout_d = snap[63];
               seg_clk_d  = 1'b0;
               bit_d      = '0;
               div_d      = '0;
               ref_d      = '0;
               busy_d     = 1'b1;
            end else if (REFRESH != 0) begin
               ref_d = ref_q + RW'(1);
            end
         end
         SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!seg_clk) begin
                  seg_clk_d = 1'b1;
               end else begin
                  seg_clk_d = 1'b0;
                  if (bit_q == 6'd63) begin
                     state_d  = LATCH;
                     seg_en_d = 1'b1;
                  end else begin
                     bit_d      = bit_q + 6'd1;
                     seg_dout_d = shreg_q[62];
                     shreg_d    = {shreg_q[61:0], 1'b0};
                  end
               end
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         LATCH: begin
            if (div_q == DIV_LAST) begin
               div_d    = '0;
               state_d  = IDLE;
               seg_en_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
            end else begin
               div_d = div_q + DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule
